// File: rtl/keyed_mux_default_if.sv
// rtl/keyed_mux_default_if.sv - lookup request/result bundle for keyed_mux_default
interface keyed_mux_default_if #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 32
);
   logic                                  in_valid;
   logic [KEY_LEN-1:0]                    key;
   logic [DATA_LEN-1:0]                   default_out;
   logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut;
   logic [DATA_LEN-1:0]                   out;
   logic                                  out_valid;
   logic                                  hit;
   logic                                  multi_hit;

   modport master (
      output in_valid, key, default_out, lut,
      input  out, out_valid, hit, multi_hit
   );

   modport slave (
      input  in_valid, key, default_out, lut,
      output out, out_valid, hit, multi_hit
   );
endinterface

// File: rtl/keyed_mux_default.sv
// rtl/keyed_mux_default.sv - registered key lookup with default value, lowest index wins
// Optional KEYED_MUX_MULTIHIT_EN builds the registered multi_hit flag and its warning.
module keyed_mux_default #(
   parameter int NR_KEY   = 2,
   parameter int KEY_LEN  = 1,
   parameter int DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   keyed_mux_default_if.slave  bus
);
   localparam int PAIR = KEY_LEN + DATA_LEN;

   logic [NR_KEY-1:0]   w_match;
   logic [DATA_LEN-1:0] w_data;
   logic                w_hit;

   logic [DATA_LEN-1:0] r_out;
   logic                r_hit;
   logic                r_valid;

   always_comb begin
      w_match = '0;
      for (int i = 0; i < NR_KEY; i++) begin
         w_match[i] = (bus.lut[i*PAIR+DATA_LEN +: KEY_LEN] == bus.key);
      end
   end

   // Walk from the top entry down so the lowest matching index overwrites last.
   always_comb begin
      w_data = bus.default_out;
      w_hit  = 1'b0;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            w_data = bus.lut[i*PAIR +: DATA_LEN];
            w_hit  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out   <= '0;
         r_hit   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_out <= w_data;
            r_hit <= w_hit;
         end
      end
   end

`ifdef KEYED_MUX_MULTIHIT_EN
   logic w_multi;
   logic w_seen;
   logic r_multi;

   always_comb begin
      w_multi = 1'b0;
      w_seen  = 1'b0;
      for (int i = 0; i < NR_KEY; i++) begin
         if (w_match[i]) begin
            if (w_seen) w_multi = 1'b1;
            w_seen = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_multi <= 1'b0;
      end else if (bus.in_valid) begin
         r_multi <= w_multi;
      end
   end

   assign bus.multi_hit = r_multi;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!rst && bus.in_valid && w_multi) begin
         $display("keyed_mux_default warning: key %0h matched multiple entries at %0t",
                  bus.key, $time);
      end
   end
`endif
`else
   assign bus.multi_hit = 1'b0;
`endif

   assign bus.out       = r_out;
   assign bus.hit       = r_hit;
   assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_keyed_mux_default.sv
// tb/tb_keyed_mux_default.sv - directed and randomized checks of keyed_mux_default
module tb_keyed_mux_default;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   keyed_mux_default_if #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) if2 ();
   keyed_mux_default_if #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(32)) if1 ();
   keyed_mux_default_if #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8))  if4 ();

   keyed_mux_default #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) u_dut2 (
      .clk(clk), .rst(rst), .bus(if2.slave));
   keyed_mux_default #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(32)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave));
   keyed_mux_default #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_dut4 (
      .clk(clk), .rst(rst), .bus(if4.slave));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic mh_exp(input int n);
`ifdef KEYED_MUX_MULTIHIT_EN
      return (n >= 2);
`else
      return 1'b0;
`endif
   endfunction

   // Reference: split the table into entries arithmetically, first match wins.
   function automatic void ref_lookup(input int nr, input int klen, input int dlen,
                                      input logic [255:0] lut, input logic [63:0] key,
                                      input logic [63:0] dflt, output logic [63:0] data,
                                      output logic hit, output int n);
      logic [255:0] entry;
      logic [63:0]  kmask, dmask, k, d;
      kmask = (64'd1 << klen) - 64'd1;
      dmask = (64'd1 << dlen) - 64'd1;
      data = dflt;
      hit  = 1'b0;
      n    = 0;
      for (int i = 0; i < nr; i++) begin
         entry = lut >> (i * (klen + dlen));
         k = entry[63:0] >> dlen;
         k = k & kmask;
         d = entry[63:0] & dmask;
         if (k == key) begin
            if (!hit) data = d;
            hit = 1'b1;
            n++;
         end
      end
   endfunction

   initial begin
      logic [63:0] m_out;
      logic        m_hit, m_mh, e_hit;
      logic [63:0] e_data;
      int          n, vcount;
      int          keys [3] = '{1, 0, 1};
      logic [31:0] outs [3] = '{32'h00100073, 32'h0, 32'h00100073};

      if2.in_valid = 1'b0; if2.key = '0; if2.default_out = '0; if2.lut = '0;
      if1.in_valid = 1'b0; if1.key = '0; if1.default_out = '0; if1.lut = '0;
      if4.in_valid = 1'b0; if4.key = '0; if4.default_out = '0; if4.lut = '0;

      rst = 1'b1;
      #2;
      check("rst_out",       if2.out, 0);
      check("rst_out_valid", if2.out_valid, 0);
      check("rst_hit",       if2.hit, 0);
      check("rst_multi_hit", if2.multi_hit, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_out",       if2.out, 0);
      check("rel_out_valid", if2.out_valid, 0);

      if2.lut = {1'b0, 32'h0, 1'b1, 32'h00100073};
      if2.key = 1'b1; if2.in_valid = 1'b1;
      step();
      check("k1_out",       if2.out, 32'h00100073);
      check("k1_hit",       if2.hit, 1);
      check("k1_out_valid", if2.out_valid, 1);
      check("k1_multi",     if2.multi_hit, 0);
      if2.in_valid = 1'b0;
      step();
      check("k1_pulse_end", if2.out_valid, 0);
      check("k1_hold",      if2.out, 32'h00100073);

      if2.key = 1'b0; if2.in_valid = 1'b1;
      step();
      check("k0_out", if2.out, 0);
      check("k0_hit", if2.hit, 1);

      vcount = 0;
      for (int i = 0; i < 3; i++) begin
         if2.key = keys[i][0]; if2.in_valid = 1'b1;
         step();
         check($sformatf("b2b_out%0d", i), if2.out, outs[i]);
         if (if2.out_valid) vcount++;
      end
      if2.in_valid = 1'b0;
      step();
      if (if2.out_valid) vcount++;
      check("b2b_valid_cycles", vcount, 3);
      check("b2b_hold", if2.out, 32'h00100073);

      if2.lut = {1'b1, 32'h22, 1'b1, 32'h11};
      if2.key = 1'b1; if2.in_valid = 1'b1;
      step();
      check("dup_out",   if2.out, 32'h11);
      check("dup_hit",   if2.hit, 1);
      check("dup_multi", if2.multi_hit, mh_exp(2));
      if2.in_valid = 1'b0;

      if1.lut = {1'b1, 32'hAAAA5555};
      if1.default_out = 32'hDEADBEEF;
      if1.key = 1'b0; if1.in_valid = 1'b1;
      step();
      check("nk1_miss_out", if1.out, 32'hDEADBEEF);
      check("nk1_miss_hit", if1.hit, 0);
      if1.key = 1'b1;
      step();
      check("nk1_hit_out", if1.out, 32'hAAAA5555);
      check("nk1_hit_hit", if1.hit, 1);
      if1.in_valid = 1'b0;

      if2.lut = {1'b0, 32'h0, 1'b1, 32'h00100073};
      if2.key = 1'b1; if2.in_valid = 1'b1;
      step();
      check("pre_rst_out", if2.out, 32'h00100073);
      if2.key = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_out",       if2.out, 0);
      check("midrst_hit",       if2.hit, 0);
      check("midrst_out_valid", if2.out_valid, 0);
      step();
      check("rst_edge_out", if2.out, 0);
      rst = 1'b0; if2.in_valid = 1'b0;
      step();
      check("post_rst_out",   if2.out, 0);
      check("post_rst_valid", if2.out_valid, 0);
      if2.key = 1'b1; if2.in_valid = 1'b1;
      step();
      check("first_after_rst", if2.out, 32'h00100073);
      check("first_after_rst_v", if2.out_valid, 1);
      if2.in_valid = 1'b0;

      m_out = 64'(if4.out); m_hit = if4.hit; m_mh = if4.multi_hit;
      for (int it = 0; it < 60; it++) begin
         if4.lut         = 40'({$urandom, $urandom});
         if4.key         = 2'($urandom_range(0, 3));
         if4.default_out = 8'($urandom);
         if4.in_valid    = ($urandom_range(0, 3) != 0);
         if (if4.in_valid) begin
            ref_lookup(4, 2, 8, 256'(if4.lut), 64'(if4.key), 64'(if4.default_out),
                       e_data, e_hit, n);
            m_out = e_data; m_hit = e_hit; m_mh = mh_exp(n);
         end
         step();
         check($sformatf("rnd%0d_out", it),   if4.out, m_out);
         check($sformatf("rnd%0d_hit", it),   if4.hit, m_hit);
         check($sformatf("rnd%0d_multi", it), if4.multi_hit, m_mh);
         check($sformatf("rnd%0d_valid", it), if4.out_valid, if4.in_valid);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
